// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator slice.
package product_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int unsigned PROD_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 16;

  // Group counter width; a single-product group still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, completed-sum stream out, both valid/ready.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;

  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_ovf
  );

endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Accumulator adder: acc + zero-extended product, with carry-out.
// PRODUCT_ACCUMULATOR_SAT_EN clamps the sum to all-ones on carry; otherwise it wraps.
module acc_adder
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw     = {1'b0, acc_i} + (ACC_W + 1)'(prod_i);
    carry_o = raw[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    sum_o   = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
`else
    sum_o   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums each group of LEN products and presents the total on a registered
// valid/ready output. Overflow policy is set by PRODUCT_ACCUMULATOR_SAT_EN.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN    = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);

  localparam int unsigned      CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] sum_d;
  logic             carry_d;
  logic             accept;

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i   (acc_q),
    .prod_i  (bus.in_prod),
    .sum_o   (sum_d),
    .carry_o (carry_d)
  );

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = (state_q == ACCUM);
  assign accept        = bus.in_valid && (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (count_q == LAST) begin
              out_acc_q   <= sum_d;
              out_ovf_q   <= ovf_q | carry_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              count_q     <= '0;
              ovf_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q   <= sum_d;
              ovf_q   <= ovf_q | carry_d;
              count_q <= count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: three instances (LEN=4/ACC_W=16,
// LEN=3/ACC_W=9, LEN=1/ACC_W=16) driven with directed product groups.
module tb_product_accumulator;

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam int OVF_ACC = 511;
`else
  localparam int OVF_ACC = 163;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid_s [3];
  logic        out_ready_s[3];
  logic [7:0]  prod_s     [3];
  logic        in_ready_r [3];
  logic        out_valid_r[3];
  logic        out_ovf_r  [3];
  logic [15:0] acc_r      [3];

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[3][$];

  product_accumulator_if #(.PROD_W(8), .ACC_W(16)) if0 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(9))  if1 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(16)) if2 ();

  product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  product_accumulator #(.PROD_W(8), .ACC_W(9),  .LEN(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.in_valid = in_valid_s[0];
  assign if0.in_prod = prod_s[0];
  assign if0.out_ready = out_ready_s[0];
  assign if1.in_valid = in_valid_s[1];
  assign if1.in_prod = prod_s[1];
  assign if1.out_ready = out_ready_s[1];
  assign if2.in_valid = in_valid_s[2];
  assign if2.in_prod = prod_s[2];
  assign if2.out_ready = out_ready_s[2];

  assign in_ready_r[0] = if0.in_ready;
  assign out_valid_r[0] = if0.out_valid;
  assign out_ovf_r[0] = if0.out_ovf;
  assign acc_r[0] = if0.out_acc;
  assign in_ready_r[1] = if1.in_ready;
  assign out_valid_r[1] = if1.out_valid;
  assign out_ovf_r[1] = if1.out_ovf;
  assign acc_r[1] = 16'(if1.out_acc);
  assign in_ready_r[2] = if2.in_ready;
  assign out_valid_r[2] = if2.out_valid;
  assign out_ovf_r[2] = if2.out_ovf;
  assign acc_r[2] = if2.out_acc;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the queue head;
  // the head is retired only on the handshake.
  always @(negedge clk) begin
    logic [16:0] e;
    for (int d = 0; d < 3; d++) begin
      if (out_valid_r[d]) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result dut%0d: got acc %0d, expected no result", d, acc_r[d]);
        end else begin
          e = exp_q[d][0];
          check($sformatf("result_acc dut%0d", d), int'(acc_r[d]), int'(e[15:0]));
          check($sformatf("result_ovf dut%0d", d), int'(out_ovf_r[d]), int'(e[16]));
          if (out_ready_s[d]) void'(exp_q[d].pop_front());
        end
      end
    end
  end

  task automatic send(input int d, input int p);
    int n = 0;
    in_valid_s[d] = 1'b1;
    prod_s[d] = 8'(p);
    @(negedge clk);
    while (!in_ready_r[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready_r[d]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: in_ready stayed 0, expected 1", d);
    end
    @(posedge clk);
    #1;
    in_valid_s[d] = 1'b0;
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      in_valid_s[d] = 1'b0;
      out_ready_s[d] = 1'b1;
      prod_s[d] = 8'd0;
    end

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_in_ready dut%0d", d), int'(in_ready_r[d]), 1);
      check($sformatf("reset_out_valid dut%0d", d), int'(out_valid_r[d]), 0);
      check($sformatf("reset_out_acc dut%0d", d), int'(acc_r[d]), 0);
      check($sformatf("reset_out_ovf dut%0d", d), int'(out_ovf_r[d]), 0);
    end
    realign();
    rst_n = 1'b1;

    // Basic group: 15+30+45+225 = 315, back-to-back
    exp_q[0].push_back({1'b0, 16'd315});
    send(0, 15); send(0, 30); send(0, 45); send(0, 225);
    @(negedge clk);
    check("basic_latency_valid", int'(out_valid_r[0]), 1);
    check("basic_bubble_in_ready", int'(in_ready_r[0]), 0);
    @(negedge clk);
    check("basic_valid_dropped", int'(out_valid_r[0]), 0);
    check("basic_in_ready_back", int'(in_ready_r[0]), 1);
    realign();

    // Backpressure: 4*225 = 900 held for 5 cycles
    exp_q[0].push_back({1'b0, 16'd900});
    send(0, 225); send(0, 225); send(0, 225);
    out_ready_s[0] = 1'b0;
    send(0, 225);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready_low", int'(in_ready_r[0]), 0);
      check("bp_out_valid_held", int'(out_valid_r[0]), 1);
    end
    realign();
    out_ready_s[0] = 1'b1;
    @(negedge clk);
    check("bp_handshake_in_ready", int'(in_ready_r[0]), 0);
    @(negedge clk);
    check("bp_after_in_ready", int'(in_ready_r[0]), 1);
    check("bp_after_out_valid", int'(out_valid_r[0]), 0);
    realign();

    // Gaps: 1,2,3,4 with 2 idle cycles between products
    exp_q[0].push_back({1'b0, 16'd10});
    for (int p = 1; p <= 4; p++) begin
      send(0, p);
      if (p < 4) repeat (2) @(posedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    realign();

    // Overflow on ACC_W=9, LEN=3: 675 wraps to 163 or clamps to 511
    exp_q[1].push_back({1'b1, 16'(OVF_ACC)});
    send(1, 225); send(1, 225); send(1, 225);
    exp_q[1].push_back({1'b0, 16'd3});
    send(1, 1); send(1, 1); send(1, 1);
    repeat (3) @(negedge clk);
    realign();

    // Reset mid-group discards the partial 200
    send(0, 100); send(0, 100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", int'(in_ready_r[0]), 1);
    check("midrst_out_valid", int'(out_valid_r[0]), 0);
    check("midrst_out_acc", int'(acc_r[0]), 0);
    check("midrst_out_ovf", int'(out_ovf_r[0]), 0);
    rst_n = 1'b1;
    exp_q[0].push_back({1'b0, 16'd10});
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    repeat (3) @(negedge clk);
    realign();

    // LEN=1: every product is a result
    exp_q[2].push_back({1'b0, 16'd7});
    exp_q[2].push_back({1'b0, 16'd8});
    exp_q[2].push_back({1'b0, 16'd9});
    send(2, 7);
    @(negedge clk);
    check("len1_bubble_in_ready", int'(in_ready_r[2]), 0);
    check("len1_first_valid", int'(out_valid_r[2]), 1);
    send(2, 8);
    send(2, 9);

    // Drain
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_pending_results", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
